// File: rtl/palette_pkg.sv
// Shared types, sizes and the channel-wise Manhattan distance helper for the
// palette index encoder.
`timescale 1ns/1ps
package palette_pkg;

    localparam int PAL_DEPTH = 16;
    localparam int IDX_W     = 4;
    localparam int CH_W      = 4;
    localparam int RGB_W     = 3 * CH_W;
    localparam int DIST_W    = CH_W + 2;

    typedef logic [RGB_W-1:0]  rgb_t;
    typedef logic [IDX_W-1:0]  pal_idx_t;
    typedef logic [IDX_W:0]    pal_cnt_t;
    typedef logic [DIST_W-1:0] dist_t;

    function automatic dist_t ch_abs_diff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
        logic [CH_W-1:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return {2'b00, d};
    endfunction

    // Sum of three channel differences; DIST_W leaves headroom for 3*(2^CH_W-1).
    function automatic dist_t rgb_dist(input rgb_t a, input rgb_t b);
        return ch_abs_diff(a[2*CH_W +: CH_W], b[2*CH_W +: CH_W])
             + ch_abs_diff(a[CH_W +: CH_W],   b[CH_W +: CH_W])
             + ch_abs_diff(a[0 +: CH_W],      b[0 +: CH_W]);
    endfunction

endpackage

// File: rtl/rgb_manhattan_dist.sv
// Combinational |dR|+|dG|+|dB| between two packed RGB colours.
`timescale 1ns/1ps
module rgb_manhattan_dist
    import palette_pkg::*;
(
    input  rgb_t  i_a,
    input  rgb_t  i_b,
    output dist_t o_dist
);

    assign o_dist = rgb_dist(i_a, i_b);

endmodule

// File: rtl/palette_index_encoder.sv
// Streams RGB pixels to palette indices, allocating first-seen colours into
// free slots and falling back to the nearest entry once the palette is full.
`timescale 1ns/1ps
module palette_index_encoder
    import palette_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset_n,
    input  logic     clear,
    input  logic     in_valid,
    output logic     in_ready,
    input  rgb_t     in_rgb,
    output logic     out_valid,
    input  logic     out_ready,
    output pal_idx_t out_index,
    output logic     out_new,
    output logic     out_approx,
    input  pal_idx_t pal_rd_addr,
    output rgb_t     pal_rd_data,
    output pal_cnt_t pal_count,
    output logic     overflow
);

    // Handshake: a pixel transfers on in_valid && in_ready; a result transfers on
    // out_valid && out_ready and is held stable until then. The single output
    // register is refilled in the same cycle it drains, giving full throughput.
    rgb_t                 r_entry [PAL_DEPTH];
    logic [PAL_DEPTH-1:0] r_valid;
    pal_cnt_t             r_count;
    logic                 r_overflow;
    logic                 r_out_valid;
    pal_idx_t             r_out_index;
    logic                 r_out_new;
    logic                 r_out_approx;
    rgb_t                 r_rd_data;

    logic     w_accept;
    logic     w_full;
    pal_idx_t w_alloc_idx;
    logic     w_hit;
    pal_idx_t w_hit_idx;
    dist_t    w_dist [PAL_DEPTH];
    dist_t    w_best_dist;
    pal_idx_t w_best_idx;

    assign in_ready    = !clear && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_full      = r_count[IDX_W];
    assign w_alloc_idx = r_count[IDX_W-1:0];

    for (genvar g = 0; g < PAL_DEPTH; g++) begin : g_dist
        rgb_manhattan_dist u_dist (
            .i_a    (r_entry[g]),
            .i_b    (in_rgb),
            .o_dist (w_dist[g])
        );
    end

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = PAL_DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_entry[i] == in_rgb)) begin
                w_hit     = 1'b1;
                w_hit_idx = pal_idx_t'(i);
            end
        end
    end

    // Only consulted when full, so every slot is valid; strict < keeps ties low.
    always_comb begin
        w_best_dist = w_dist[0];
        w_best_idx  = '0;
        for (int i = 1; i < PAL_DEPTH; i++) begin
            if (w_dist[i] < w_best_dist) begin
                w_best_dist = w_dist[i];
                w_best_idx  = pal_idx_t'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_accept && !w_hit && !w_full) begin
            r_entry[w_alloc_idx] <= in_rgb;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_valid      <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_out_new    <= 1'b0;
            r_out_approx <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_rd_data <= r_valid[pal_rd_addr] ? r_entry[pal_rd_addr] : '0;
            if (clear) begin
                r_valid    <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                if (w_hit) begin
                    r_out_index  <= w_hit_idx;
                    r_out_new    <= 1'b0;
                    r_out_approx <= 1'b0;
                end else if (!w_full) begin
                    r_valid[w_alloc_idx] <= 1'b1;
                    r_count              <= r_count + 1'b1;
                    r_out_index          <= w_alloc_idx;
                    r_out_new            <= 1'b1;
                    r_out_approx         <= 1'b0;
                end else begin
                    r_out_index  <= w_best_idx;
                    r_out_new    <= 1'b0;
                    r_out_approx <= 1'b1;
                    r_overflow   <= 1'b1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_index   = r_out_index;
    assign out_new     = r_out_new;
    assign out_approx  = r_out_approx;
    assign pal_rd_data = r_rd_data;
    assign pal_count   = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_palette_index_encoder.sv
// Randomised and directed bench for palette_index_encoder with a queue-based
// palette model and a decoupled output scoreboard.
`timescale 1ns/1ps
module tb_palette_index_encoder;
    import palette_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_rgb;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic        out_new;
    logic        out_approx;
    logic [3:0]  pal_rd_addr;
    logic [11:0] pal_rd_data;
    logic [4:0]  pal_count;
    logic        overflow;

    always #5 Clk = ~Clk;

    palette_index_encoder dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rgb      (in_rgb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_new     (out_new),
        .out_approx  (out_approx),
        .pal_rd_addr (pal_rd_addr),
        .pal_rd_data (pal_rd_data),
        .pal_count   (pal_count),
        .overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Expected results packed as {index, new, approx}.
    logic [5:0]  exp_q[$];
    logic [11:0] pal[$];
    bit          ovf;
    logic [11:0] rd_exp;
    bit          rd_pending;
    logic [11:0] pool [32];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int manhattan(input logic [11:0] a, input logic [11:0] b);
        int dr, dg, db;
        dr = int'(a[11:8]) - int'(b[11:8]);
        dg = int'(a[7:4])  - int'(b[7:4]);
        db = int'(a[3:0])  - int'(b[3:0]);
        return (dr < 0 ? -dr : dr) + (dg < 0 ? -dg : dg) + (db < 0 ? -db : db);
    endfunction

    task automatic model_encode(input logic [11:0] rgb, output logic [5:0] res);
        int idx;
        int best;
        int bd;
        int d;
        idx = -1;
        for (int i = 0; i < pal.size(); i++) begin
            if (pal[i] == rgb) begin
                idx = i;
                break;
            end
        end
        if (idx >= 0) begin
            res = {4'(idx), 2'b00};
        end else if (pal.size() < 16) begin
            res = {4'(pal.size()), 2'b10};
            pal.push_back(rgb);
        end else begin
            best = 0;
            bd   = 1000;
            for (int i = 0; i < pal.size(); i++) begin
                d = manhattan(pal[i], rgb);
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
            res = {4'(best), 2'b01};
            ovf = 1'b1;
        end
    endtask

    // One cycle: check committed state, drive inputs, then predict the upcoming edge.
    task automatic step(input bit v, input logic [11:0] rgb, input bit ordy, input bit clr,
                        input logic [3:0] ra, output bit acc);
        logic [5:0] r;
        bit         exp_rdy;
        @(negedge Clk);
        check("pal_count", int'(pal_count), pal.size());
        check("overflow", int'(overflow), int'(ovf));
        if (rd_pending) check("pal_rd_data", int'(pal_rd_data), int'(rd_exp));
        in_valid    = v;
        in_rgb      = rgb;
        out_ready   = ordy;
        clear       = clr;
        pal_rd_addr = ra;
        #1;
        exp_rdy = !clr && (!out_valid || ordy);
        check("in_ready", int'(in_ready), int'(exp_rdy));
        rd_exp     = (int'(ra) < pal.size()) ? pal[ra] : 12'h000;
        rd_pending = 1'b1;
        acc = v && in_ready;
        if (acc) begin
            model_encode(rgb, r);
            exp_q.push_back(r);
        end
        if (clr) begin
            pal.delete();
            ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        exp_q.delete();
        pal.delete();
        ovf = 1'b0;
        @(negedge Clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_flags", int'({out_new, out_approx}), 0);
        check("rst_pal_count", int'(pal_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_rd_data", int'(pal_rd_data), 0);
        Reset_n    = 1'b1;
        rd_exp     = 12'h000;
        rd_pending = 1'b1;
    endtask

    // Monitor: pops on every output transfer and checks hold-while-stalled.
    bit         hold_v = 1'b0;
    logic [5:0] hold_val;
    always @(negedge Clk) begin
        logic [5:0] cur;
        #2;
        cur = {out_index, out_new, out_approx};
        if (!Reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(cur), int'(hold_val));
            end
            hold_v = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    check("output_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("result", int'(cur), int'(exp_q.pop_front()));
                end else begin
                    hold_v   = 1'b1;
                    hold_val = cur;
                end
            end
        end
    end

    initial begin
        bit          a;
        bit          have;
        logic [11:0] px;
        Reset_n     = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_rgb      = '0;
        out_ready   = 1'b1;
        pal_rd_addr = '0;
        rd_pending  = 1'b0;
        ovf         = 1'b0;
        for (int i = 0; i < 32; i++) pool[i] = 12'($urandom);

        // Repeat of a first-seen colour maps back to its slot.
        do_reset();
        step(1, 12'h8D0, 1, 0, 4'd0, a);
        step(1, 12'h000, 1, 0, 4'd1, a);
        step(1, 12'h8D0, 1, 0, 4'd0, a);
        step(0, 12'h000, 1, 0, 4'd1, a);
        step(0, 12'h000, 1, 0, 4'd0, a);

        // Fill all sixteen slots, then force a nearest-entry lookup.
        do_reset();
        for (int k = 0; k < 16; k++) step(1, 12'(k << 8), 1, 0, 4'(k), a);
        step(0, 12'h000, 1, 0, 4'd15, a);
        step(1, 12'h810, 1, 0, 4'd8, a);
        step(1, 12'h8F0, 1, 0, 4'd9, a);
        step(0, 12'h000, 1, 0, 4'd0, a);

        // Stall the consumer with a pixel waiting; it must go through exactly once.
        step(1, 12'h345, 1, 0, 4'd3, a);
        for (int k = 0; k < 3; k++) step(1, 12'h0F0, 0, 0, 4'd2, a);
        a = 1'b0;
        for (int k = 0; k < 4 && !a; k++) step(1, 12'h0F0, 1, 0, 4'd2, a);
        check("stall_release_accept", int'(a), 1);

        // Clear mid-stream: nothing accepted that cycle, palette restarts.
        step(1, 12'h111, 1, 0, 4'd0, a);
        step(1, 12'h222, 1, 1, 4'd0, a);
        check("clear_blocks_accept", int'(a), 0);
        step(1, 12'h333, 1, 0, 4'd0, a);
        step(0, 12'h000, 1, 0, 4'd0, a);

        // Reset while a result is stalled at the output.
        step(1, 12'hABC, 0, 0, 4'd0, a);
        step(0, 12'h000, 0, 0, 4'd0, a);
        do_reset();
        step(0, 12'h000, 1, 0, 4'd0, a);
        step(0, 12'h000, 1, 0, 4'd0, a);

        // Random traffic from a small colour pool so matches and overflow both occur.
        have = 1'b0;
        px   = '0;
        for (int i = 0; i < 1200; i++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                have = 1'b1;
                px   = ($urandom_range(0, 3) == 0) ? 12'($urandom) : pool[$urandom_range(0, 31)];
            end
            step(have, px, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0),
                 4'($urandom_range(0, 15)), a);
            if (a) have = 1'b0;
            if (i == 700) do_reset();
        end

        for (int k = 0; k < 4; k++) step(0, 12'h000, 1, 0, 4'd0, a);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
